// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO access bundle between the control unit and the
// iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shift-add or
// restoring-subtract step per clock, sign fix-up in a final cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input logic                clk,
  input logic                rst,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             bz;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] araw;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, dz_r;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_neg;

  always_comb begin
    a_neg  = bus.op[0] & bus.a[WIDTH-1];
    b_neg  = bus.op[0] & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    // Multiply: upper half accumulates, multiplier shifts out of the low half.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    mul_step = {sum, acc[WIDTH-1:1]};
    // Divide: remainder:quotient shifted left, quotient bits enter at LSB.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = rem_sh >= {1'b0, opb};
    sub      = rem_sh[WIDTH-1:0] - opb;
    div_step = ge ? {sub, acc[WIDTH-2:0], 1'b1}
                  : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod_neg = -acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (cnt == CW'(STEPS - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bz     <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      araw   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
          if (bus.start) begin
            // Same load serves both: multiplier/dividend low, operand b or a held.
            is_div <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            bz     <= (bus.b == '0);
            araw   <= bus.a;
            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
            opb    <= bus.op[1] ? b_mag : a_mag;
            cnt    <= '0;
            dz_r   <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= is_div ? div_step : mul_step;
        end
        FIX: begin
          if (!is_div) begin
            {hi_r, lo_r} <= neg_q ? prod_neg : acc;
          end else if (bz) begin
            hi_r <= araw;
            lo_r <= '1;
            dz_r <= 1'b1;
          end else begin
            lo_r <= neg_q ? prod_neg[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_r <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule
